// File: rtl/basket_pkg.sv
// Shared types, widths and defaults for the basket controller.
// Optional running total is enabled by defining BASKET_TOTAL_EN.
package basket_pkg;

    localparam int unsigned BASKET_DEPTH_DEFAULT = 8;
    localparam int unsigned PRICE_W_DEFAULT      = 8;
    localparam int unsigned ID_W                 = 4;
    localparam int unsigned QTY_W                = 4;
    localparam int unsigned MAX_SLOTS            = 16;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        WRITE,
        SHIFT,
        CLEAR
    } state_t;

    // Quantities saturate at the all-ones value instead of wrapping.
    function automatic logic [QTY_W-1:0] qty_sat_add(input logic [QTY_W-1:0] a,
                                                     input logic [QTY_W-1:0] b);
        logic [QTY_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[QTY_W] ? '1 : s[QTY_W-1:0];
    endfunction

endpackage

// File: rtl/product_price_rom.sv
// Combinational 16-entry unit-price table indexed by product ID.
// Only instantiated when BASKET_TOTAL_EN is defined.
module product_price_rom
    import basket_pkg::*;
#(
    parameter int unsigned PRICE_W = PRICE_W_DEFAULT
) (
    input  logic [ID_W-1:0]    product_id,
    output logic [PRICE_W-1:0] price
);

    always_comb begin
        price = '0;
        case (product_id)
            4'd0:  price = PRICE_W'(12);
            4'd1:  price = PRICE_W'(25);
            4'd2:  price = PRICE_W'(7);
            4'd3:  price = PRICE_W'(40);
            4'd4:  price = PRICE_W'(15);
            4'd5:  price = PRICE_W'(99);
            4'd6:  price = PRICE_W'(3);
            4'd7:  price = PRICE_W'(60);
            4'd8:  price = PRICE_W'(18);
            4'd9:  price = PRICE_W'(22);
            4'd10: price = PRICE_W'(5);
            4'd11: price = PRICE_W'(33);
            4'd12: price = PRICE_W'(80);
            4'd13: price = PRICE_W'(11);
            4'd14: price = PRICE_W'(9);
            4'd15: price = PRICE_W'(50);
            default: price = '0;
        endcase
    end

endmodule

// File: rtl/basket_controller.sv
// Shopping-basket list controller: add (merge or append), cancel (compact), clear.
// Define BASKET_TOTAL_EN to maintain TotalPrice from product_price_rom.
module basket_controller
    import basket_pkg::*;
#(
    parameter int unsigned BASKET_DEPTH = BASKET_DEPTH_DEFAULT,
    parameter int unsigned PRICE_W      = PRICE_W_DEFAULT
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              Add_Pulse,
    input  logic [ID_W-1:0]   Add_ProductID,
    input  logic [QTY_W-1:0]  Add_Quantity,
    input  logic              Cancel_Pulse,
    input  logic [3:0]        Cancel_Index,
    input  logic              Clear_Pulse,
    input  logic [3:0]        Read_Index,
    output logic [ID_W-1:0]   Read_ProductID,
    output logic [QTY_W-1:0]  Read_Quantity,
    output logic [3:0]        BasketProductNum,
    output logic              Busy,
    output logic              Full,
    output logic              Err_Pulse,
    output logic [15:0]       TotalPrice
);

    state_t            state, state_nx;
    logic [ID_W-1:0]   ids  [MAX_SLOTS];
    logic [QTY_W-1:0]  qtys [MAX_SLOTS];
    logic [3:0]        count;
    logic [ID_W-1:0]   op_id;
    logic [QTY_W-1:0]  op_qty;
    logic [3:0]        idx;
    logic [3:0]        match_idx;
    logic              match_found;
    logic              err_q;
    logic              any_req, add_req, cancel_ok;
    logic              search_last, shift_last, hit;
    logic [QTY_W-1:0]  merged_qty;

    assign any_req     = Add_Pulse | Cancel_Pulse | Clear_Pulse;
    assign add_req     = Add_Pulse && (Add_Quantity != '0);
    assign cancel_ok   = Cancel_Index < count;
    assign search_last = ({1'b0, idx} + 5'd1) >= {1'b0, count};
    assign shift_last  = ({1'b0, idx} + 5'd2) >= {1'b0, count};
    assign hit         = (idx < count) && (ids[idx] == op_id);
    assign merged_qty  = qty_sat_add(qtys[match_idx], op_qty);

    assign BasketProductNum = count;
    assign Busy             = (state != IDLE);
    assign Full             = (count == 4'(BASKET_DEPTH));
    assign Err_Pulse        = err_q | ((state == WRITE) && !match_found && Full);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (Clear_Pulse)       state_nx = CLEAR;
                else if (Cancel_Pulse) state_nx = cancel_ok ? SHIFT : IDLE;
                else if (add_req)      state_nx = SEARCH;
            end
            SEARCH:  if (search_last) state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            SHIFT:   if (shift_last) state_nx = IDLE;
            CLEAR:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // idx doubles as the scan pointer in SEARCH and the hole position in SHIFT.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
                ids[i]  <= '0;
                qtys[i] <= '0;
            end
            count       <= '0;
            op_id       <= '0;
            op_qty      <= '0;
            idx         <= '0;
            match_idx   <= '0;
            match_found <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= (state != IDLE) && any_req;
            case (state)
                IDLE: begin
                    if (Clear_Pulse) begin
                        // handled in CLEAR
                    end else if (Cancel_Pulse) begin
                        if (cancel_ok) begin
                            idx    <= Cancel_Index;
                            op_id  <= ids[Cancel_Index];
                            op_qty <= qtys[Cancel_Index];
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (add_req) begin
                        op_id       <= Add_ProductID;
                        op_qty      <= Add_Quantity;
                        idx         <= '0;
                        match_found <= 1'b0;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    idx <= idx + 4'd1;
                end
                WRITE: begin
                    if (match_found) begin
                        qtys[match_idx] <= merged_qty;
                    end else if (!Full) begin
                        ids[count]  <= op_id;
                        qtys[count] <= op_qty;
                        count       <= count + 4'd1;
                    end
                end
                SHIFT: begin
                    if (({1'b0, idx} + 5'd1) < {1'b0, count}) begin
                        ids[idx]  <= ids[idx + 4'd1];
                        qtys[idx] <= qtys[idx + 4'd1];
                    end
                    if (shift_last) begin
                        ids[count - 4'd1]  <= '0;
                        qtys[count - 4'd1] <= '0;
                        count              <= count - 4'd1;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                CLEAR: begin
                    for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
                        ids[i]  <= '0;
                        qtys[i] <= '0;
                    end
                    count <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Read_ProductID = '0;
        Read_Quantity  = '0;
        if (Read_Index < count) begin
            Read_ProductID = ids[Read_Index];
            Read_Quantity  = qtys[Read_Index];
        end
    end

`ifdef BASKET_TOTAL_EN
    logic [PRICE_W-1:0] unit_price;
    logic [15:0]        total_q;
    logic [15:0]        add_delta;

    product_price_rom #(.PRICE_W(PRICE_W)) u_price_rom (
        .product_id (op_id),
        .price      (unit_price)
    );

    always_comb begin
        add_delta = '0;
        if (match_found)
            add_delta = 16'(unit_price) * 16'(merged_qty - qtys[match_idx]);
        else if (!Full)
            add_delta = 16'(unit_price) * 16'(op_qty);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            total_q <= '0;
        end else begin
            case (state)
                WRITE:   total_q <= total_q + add_delta;
                SHIFT:   if (shift_last) total_q <= total_q - 16'(unit_price) * 16'(op_qty);
                CLEAR:   total_q <= '0;
                default: ;
            endcase
        end
    end

    assign TotalPrice = total_q;
`else
    assign TotalPrice = '0;
`endif

endmodule

// File: doc/basket_controller.md
BASKET_CONTROLLER -- requirements
Module: basket_controller

Interface
REQ-001 Parameter BASKET_DEPTH, default 8, number of basket entries (2..15).
REQ-002 Parameter PRICE_W, default 8, width of one unit price.
REQ-003 CLOCK_50  in  1  single system clock; all state changes on rising edge.
REQ-004 RESET_N  in  1  asynchronous active-low reset.
REQ-005 Add_Pulse  in  1  one-cycle request: add Add_Quantity units of Add_ProductID.
REQ-006 Add_ProductID  in  4  product ID (0..15) for the add request.
REQ-007 Add_Quantity  in  4  quantity for the add request (0..15).
REQ-008 Cancel_Pulse  in  1  one-cycle request: remove the entry at Cancel_Index.
REQ-009 Cancel_Index  in  4  entry index to remove.
REQ-010 Clear_Pulse  in  1  one-cycle request: empty the basket.
REQ-011 Read_Index  in  4  combinational read port index for display and hover logic.
REQ-012 Read_ProductID / Read_Quantity  out  4/4  entry at Read_Index; 0/0 if Read_Index >= BasketProductNum.
REQ-013 BasketProductNum  out  4  number of valid entries.
REQ-014 Busy  out  1  high while a request is in progress.
REQ-015 Full  out  1  high when BasketProductNum == BASKET_DEPTH.
REQ-016 Err_Pulse  out  1  one-cycle flag for a rejected request.
REQ-017 TotalPrice  out  16  running basket total (see Configuration).

Function
REQ-018 States: IDLE, SEARCH, WRITE, SHIFT, CLEAR; requests are sampled only in IDLE.
REQ-019 Priority for same-cycle requests in IDLE: Clear > Cancel > Add; lower-priority pulses that cycle are dropped with no Err_Pulse.
REQ-020 Any request pulse while Busy is dropped and Err_Pulse is asserted on the next cycle.
REQ-021 Add with Add_Quantity == 0 is ignored, with no state change and no error.
REQ-022 Add: IDLE -> SEARCH, which latches ID and quantity and scans one entry per cycle from index 0, so SEARCH lasts max(BasketProductNum,1) cycles; then WRITE, which lasts 1 cycle; then IDLE.
REQ-023 Match found: quantity = min(old + Add_Quantity, 15) (saturating); BasketProductNum is unchanged.
REQ-024 No match and not Full: append at index BasketProductNum and increment the count.
REQ-025 No match and Full: no entry is written, and Err_Pulse is asserted in the WRITE cycle.
REQ-026 Cancel with Cancel_Index >= BasketProductNum: stay in IDLE and assert Err_Pulse on the next cycle.
REQ-027 Cancel valid: SHIFT moves entry i+1 to entry i, one entry per cycle, from Cancel_Index up to count-2; it then clears the last entry, decrements the count and returns to IDLE.
REQ-028 Clear: CLEAR is a single cycle that zeroes all entries, the count and TotalPrice, then returns to IDLE.
REQ-029 Busy = (state != IDLE), registered.
REQ-030 Entry order is insertion order; cancelling compacts the list without reordering.

Reset
REQ-031 Asserting RESET_N low immediately forces IDLE, zeroes all entries, BasketProductNum, TotalPrice, Busy and Err_Pulse, and clears Full.
REQ-032 Reset mid-SEARCH, WRITE or SHIFT aborts the operation; no partial entry survives.

Configuration
REQ-033 Macro BASKET_TOTAL_EN defined: TotalPrice is maintained as follows.
- On add, it increases by price(ID) * (new_qty - old_qty).
- On cancel, it decreases by price(ID) * qty.
- It is updated in the WRITE cycle or the final SHIFT cycle respectively.
REQ-034 Macro BASKET_TOTAL_EN undefined: TotalPrice is tied to 0 and the price ROM is not instantiated.

Structure
REQ-035 Shared package basket_pkg holds the state enumeration, the BASKET_DEPTH default, PRICE_W, and the product-ID and quantity widths.
REQ-036 One sub-module, product_price_rom: combinational 16 x PRICE_W unit-price table indexed by product ID, instantiated only under BASKET_TOTAL_EN.

Verification
REQ-037 Reset, then Add(ID=3,Q=2) -> Busy high for 2 cycles; then BasketProductNum=1, entry0=(3,2), TotalPrice=2*price(3).
REQ-038 Add(3,2), Add(3,14) -> entry0 quantity saturates to 15; count stays 1; TotalPrice=15*price(3).
REQ-039 Eight distinct adds, then Add(9,1) -> Full=1; Err_Pulse for one cycle; count stays 8; entries unchanged.
REQ-040 Entries (1,1),(2,2),(4,3), then Cancel_Index=0 -> entries (2,2),(4,3); count=2; Busy for 2 cycles; TotalPrice reduced by price(1).
REQ-041 Cancel_Index=5 with count 2 -> Err_Pulse; no change. Clear_Pulse and Add_Pulse in the same cycle -> basket empty; add dropped.
REQ-042 Assert RESET_N during SHIFT -> all outputs 0 at once; the next Add(5,1) lands at index 0.
